ccg_eval_scheduler: RTL

- Sequencer that drives one synthesized combinational benchmark block (29 inputs x0..x28, 27 outputs f1..f27) over a pseudo-random vector stream.
- Waits a fixed settle time per vector, captures the response and compacts it into a MISR signature.
- Also counts f1 ones and flags any response whose outputs disagree with f1.
- Sits between a host/test controller (start/result handshake) and the benchmark instance (vec_o -> x, f -> resp_i).

---
 rtl/ccg_eval_pkg.sv | 23 ++
 rtl/ccg_misr.sv | 30 +++
 rtl/ccg_eval_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ccg_eval_pkg.sv
// Shared state type, tap constants and default widths for the
// ccg_eval_scheduler benchmark sequencer.
package ccg_eval_pkg;

   localparam int DEF_IN_W       = 29;
   localparam int DEF_OUT_W      = 27;
   localparam int DEF_CNT_W      = 16;
   localparam int DEF_SETTLE_CYC = 2;

   // Feedback taps: LFSR uses bits 28,26; MISR uses bits 26,4,1,0
   localparam logic [DEF_IN_W-1:0]  LFSR_TAPS = 29'h1400_0000;
   localparam logic [DEF_OUT_W-1:0] MISR_TAPS = 27'h400_0013;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      APPLY,
      SETTLE,
      CAPTURE,
      DONE
   } state_t;

endpackage

// File: rtl/ccg_misr.sv
// Multiple-input signature register that compacts benchmark responses;
// clear has priority over enable.
module ccg_misr
   import ccg_eval_pkg::*;
#(
   parameter int W = DEF_OUT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] data,
   output logic [W-1:0] sig
);

   logic feedback;

   assign feedback = ^(sig & W'(MISR_TAPS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= '0;
      end else if (clear) begin
         sig <= '0;
      end else if (enable) begin
         sig <= {sig[W-2:0], feedback} ^ data;
      end
   end

endmodule

// File: rtl/ccg_eval_scheduler.sv
// Drives a combinational benchmark with an LFSR vector stream, waits a settle
// time per vector and compacts the responses into a MISR signature.
module ccg_eval_scheduler
   import ccg_eval_pkg::*;
#(
   parameter int IN_W       = DEF_IN_W,
   parameter int OUT_W      = DEF_OUT_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [IN_W-1:0]  seed_i,
   input  logic [CNT_W-1:0] vec_count_i,
   input  logic             abort_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic [IN_W-1:0]  vec_o,
   output logic             vec_valid_o,
   input  logic [OUT_W-1:0] resp_i,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic [OUT_W-1:0] misr_o,
   output logic [CNT_W-1:0] ones_cnt_o,
   output logic             mismatch_o,
   output logic [CNT_W-1:0] first_fail_idx_o
);

   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   state_t           state;
   state_t           next_state;
   logic [IN_W-1:0]  seed_reg;
   logic [CNT_W-1:0] count_reg;
   logic [IN_W-1:0]  lfsr;
   logic [IN_W-1:0]  lfsr_next;
   logic [CNT_W-1:0] idx;
   logic [SET_W-1:0] settle_cnt;
   logic             settle_last;
   logic             resp_mixed;
   logic             misr_clear;
   logic             misr_enable;

   assign lfsr_next   = {lfsr[IN_W-2:0], ^(lfsr & IN_W'(LFSR_TAPS))};
   assign settle_last = (settle_cnt == SET_W'(SETTLE_CYC - 1));
   assign resp_mixed  = (resp_i != '0) && (resp_i != '1);
   assign misr_clear  = (state == LOAD) && !abort_i;
   assign misr_enable = (state == CAPTURE) && !abort_i;

   // Abort wins over every in-run transition, including the CAPTURE update
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start_i) next_state = LOAD;
         LOAD:    if (abort_i) next_state = IDLE;
                  else if (count_reg == '0) next_state = DONE;
                  else next_state = APPLY;
         APPLY:   if (abort_i) next_state = IDLE;
                  else next_state = (SETTLE_CYC > 0) ? SETTLE : CAPTURE;
         SETTLE:  if (abort_i) next_state = IDLE;
                  else if (settle_last) next_state = CAPTURE;
         CAPTURE: if (abort_i) next_state = IDLE;
                  else if (idx == count_reg - 1'b1) next_state = DONE;
                  else next_state = APPLY;
         DONE:    if (result_ready_i) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         ready_o          <= 1'b1;
         busy_o           <= 1'b0;
         vec_valid_o      <= 1'b0;
         result_valid_o   <= 1'b0;
         vec_o            <= '0;
         seed_reg         <= '0;
         count_reg        <= '0;
         lfsr             <= '0;
         idx              <= '0;
         settle_cnt       <= '0;
         ones_cnt_o       <= '0;
         mismatch_o       <= 1'b0;
         first_fail_idx_o <= '0;
      end else begin
         state          <= next_state;
         ready_o        <= (next_state == IDLE);
         busy_o         <= next_state inside {LOAD, APPLY, SETTLE, CAPTURE};
         vec_valid_o    <= next_state inside {APPLY, SETTLE, CAPTURE};
         result_valid_o <= (next_state == DONE);

         case (state)
            IDLE: begin
               if (start_i) begin
                  seed_reg  <= (seed_i == '0) ? IN_W'(1) : seed_i;
                  count_reg <= vec_count_i;
               end
            end
            LOAD: begin
               if (!abort_i) begin
                  lfsr             <= seed_reg;
                  idx              <= '0;
                  ones_cnt_o       <= '0;
                  mismatch_o       <= 1'b0;
                  first_fail_idx_o <= '0;
               end
            end
            APPLY:   settle_cnt <= '0;
            SETTLE:  settle_cnt <= settle_cnt + 1'b1;
            CAPTURE: begin
               if (!abort_i) begin
                  ones_cnt_o <= ones_cnt_o + CNT_W'(resp_i[0]);
                  if (resp_mixed && !mismatch_o) begin
                     mismatch_o       <= 1'b1;
                     first_fail_idx_o <= idx;
                  end
                  lfsr <= lfsr_next;
                  idx  <= idx + 1'b1;
               end
            end
            default: ;
         endcase

         // The vector only moves when a new APPLY begins
         if (next_state == APPLY) begin
            vec_o <= (state == LOAD) ? seed_reg : lfsr_next;
         end
      end
   end

   ccg_misr #(
      .W(OUT_W)
   ) u_misr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (misr_clear),
      .enable (misr_enable),
      .data   (resp_i),
      .sig    (misr_o)
   );

endmodule
